// File: rtl/parity_frame_rx_if.sv
// Output side of the parity frame receiver: the received word, its error flags and the
// valid/ready handshake toward the consuming logic.
interface parity_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              data_rdy;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_rdy
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_rdy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial receiver for start / DATA_W data bits (LSB first) / parity / stop frames.
// It checks parity and framing, then holds each word on a valid/ready handshake.
module parity_frame_rx #(
  parameter int DATA_W     = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bit_en,
  input  logic                    rx_in,
  parity_frame_rx_if.master       rx_if,
  output logic                    overrun,
  output logic                    busy
);

  localparam int   CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
  localparam logic ODD   = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              p_rx;
  logic              complete;
  logic              transfer;

  assign complete = bit_en && (state == STOP);
  assign transfer = rx_if.data_valid && rx_if.data_rdy;
  assign busy     = (state != IDLE);

  // A completing frame takes priority over a transfer: the new word loads and stays
  // valid, and overrun is raised only when the old word was neither consumed nor read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      shreg            <= '0;
      p_rx             <= 1'b0;
      rx_if.data_out   <= '0;
      rx_if.data_valid <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx_in) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= (shreg >> 1) | (DATA_W'(rx_in) << (DATA_W - 1));
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            p_rx  <= rx_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end

      if (complete) begin
        rx_if.data_out   <= shreg;
        rx_if.parity_err <= p_rx ^ (^shreg) ^ ODD;
        rx_if.frame_err  <= ~rx_in;
        rx_if.data_valid <= 1'b1;
        if (rx_if.data_valid && !rx_if.data_rdy) begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        rx_if.data_valid <= 1'b0;
        overrun          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity receiver share
// the serial line; expected words and flags are hand-computed per frame.
module tb_parity_frame_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic bit_en;
  logic rx_in;
  logic rdy;
  logic ov_e, busy_e, ov_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_W(4)) even_if ();
  parity_frame_rx_if #(.DATA_W(4)) odd_if ();

  assign even_if.data_rdy = rdy;
  assign odd_if.data_rdy  = rdy;

  parity_frame_rx #(.DATA_W(4), .PARITY_ODD(0)) u_even (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_en (bit_en),
    .rx_in  (rx_in),
    .rx_if  (even_if.master),
    .overrun(ov_e),
    .busy   (busy_e)
  );

  parity_frame_rx #(.DATA_W(4), .PARITY_ODD(1)) u_odd (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_en (bit_en),
    .rx_in  (rx_in),
    .rx_if  (odd_if.master),
    .overrun(ov_o),
    .busy   (busy_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit period: period-1 strobeless cycles with the line glitched, then the sample edge.
  task automatic sendBit(input logic b, input int period);
    for (int i = 1; i < period; i++) begin
      bit_en = 1'b0;
      rx_in  = ~b;
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    rx_in  = b;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic p, input logic s,
                               input int period, input logic rdy_at_stop);
    sendBit(1'b0, period);
    for (int i = 0; i < 4; i++) sendBit(d[i], period);
    sendBit(p, period);
    rdy = rdy_at_stop;
    sendBit(s, period);
    rdy = 1'b0;
  endtask

  task automatic consume();
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    rdy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", even_if.data_valid, 0);
    checkOutput("rst_data", even_if.data_out, 0);
    checkOutput("rst_perr", even_if.parity_err, 0);
    checkOutput("rst_ferr", even_if.frame_err, 0);
    checkOutput("rst_overrun", ov_e, 0);
    checkOutput("rst_busy", busy_e, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame 1011 with even parity 1
    applyStimulus(4'b1011, 1'b1, 1'b1, 1, 1'b0);
    checkOutput("f1_data", even_if.data_out, 4'b1011);
    checkOutput("f1_valid", even_if.data_valid, 1);
    checkOutput("f1_perr", even_if.parity_err, 0);
    checkOutput("f1_ferr", even_if.frame_err, 0);
    checkOutput("f1_busy", busy_e, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("f1_hold_valid", even_if.data_valid, 1);
    checkOutput("f1_hold_data", even_if.data_out, 4'b1011);
    consume();
    checkOutput("f1_consumed", even_if.data_valid, 0);
    consume();
    checkOutput("idle_rdy_noeffect", even_if.data_valid, 0);

    // Same data with wrong parity
    applyStimulus(4'b1011, 1'b0, 1'b1, 1, 1'b0);
    checkOutput("f2_data", even_if.data_out, 4'b1011);
    checkOutput("f2_perr", even_if.parity_err, 1);
    checkOutput("f2_ferr", even_if.frame_err, 0);
    consume();

    // 0000 with parity 1: odd receiver accepts, even receiver flags
    applyStimulus(4'b0000, 1'b1, 1'b1, 1, 1'b0);
    checkOutput("odd_valid", odd_if.data_valid, 1);
    checkOutput("odd_data", odd_if.data_out, 4'b0000);
    checkOutput("odd_perr", odd_if.parity_err, 0);
    checkOutput("even_perr_0000", even_if.parity_err, 1);
    consume();

    // Framing error, then line held low restarts immediately
    applyStimulus(4'b0110, 1'b0, 1'b0, 1, 1'b0);
    checkOutput("fe_valid", even_if.data_valid, 1);
    checkOutput("fe_ferr", even_if.frame_err, 1);
    checkOutput("fe_perr", even_if.parity_err, 0);
    checkOutput("fe_data", even_if.data_out, 4'b0110);
    sendBit(1'b0, 1);
    checkOutput("fe_restart_busy", busy_e, 1);
    consume();
    for (int i = 0; i < 4; i++) sendBit(1'b0, 1);
    sendBit(1'b0, 1);
    sendBit(1'b1, 1);
    checkOutput("fe_next_valid", even_if.data_valid, 1);
    checkOutput("fe_next_data", even_if.data_out, 4'b0000);
    checkOutput("fe_next_ferr", even_if.frame_err, 0);
    checkOutput("fe_next_overrun", ov_e, 0);
    consume();

    // Overrun: 3 then A without reading
    applyStimulus(4'h3, 1'b0, 1'b1, 1, 1'b0);
    checkOutput("ov_first_overrun", ov_e, 0);
    applyStimulus(4'hA, 1'b0, 1'b1, 1, 1'b0);
    checkOutput("ov_data", even_if.data_out, 4'hA);
    checkOutput("ov_flag", ov_e, 1);
    checkOutput("ov_valid", even_if.data_valid, 1);
    consume();
    checkOutput("ov_clr_valid", even_if.data_valid, 0);
    checkOutput("ov_clr_flag", ov_e, 0);

    // Transfer coinciding with completion: new word stays valid, no overrun
    applyStimulus(4'h9, 1'b0, 1'b1, 1, 1'b0);
    applyStimulus(4'h6, 1'b0, 1'b1, 1, 1'b1);
    checkOutput("sim_data", even_if.data_out, 4'h6);
    checkOutput("sim_valid", even_if.data_valid, 1);
    checkOutput("sim_overrun", ov_e, 0);
    consume();

    // Sparse strobe with glitches between samples
    applyStimulus(4'h5, 1'b0, 1'b1, 4, 1'b0);
    checkOutput("slow_data", even_if.data_out, 4'h5);
    checkOutput("slow_valid", even_if.data_valid, 1);
    checkOutput("slow_perr", even_if.parity_err, 0);
    checkOutput("slow_ferr", even_if.frame_err, 0);

    // Reset after two data bits, with the previous word still pending
    sendBit(1'b0, 1);
    sendBit(1'b1, 1);
    sendBit(1'b0, 1);
    checkOutput("mid_busy_before", busy_e, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy_e, 0);
    checkOutput("mid_rst_valid", even_if.data_valid, 0);
    checkOutput("mid_rst_data", even_if.data_out, 0);
    checkOutput("mid_rst_overrun", ov_e, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'hC, 1'b0, 1'b1, 1, 1'b0);
    checkOutput("post_rst_data", even_if.data_out, 4'hC);
    checkOutput("post_rst_valid", even_if.data_valid, 1);
    checkOutput("post_rst_perr", even_if.parity_err, 0);
    checkOutput("post_rst_ferr", even_if.frame_err, 0);
    checkOutput("post_rst_overrun", ov_e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
